// File: rtl/elevator_call_panel_pkg.sv
// Shared elevator definitions: floor/direction encodings and the call-panel state enum.
package elevator_pkg;

  localparam int NFLOORS = 4;

  localparam logic [1:0] FLOOR_A = 2'd0;
  localparam logic [1:0] FLOOR_B = 2'd1;
  localparam logic [1:0] FLOOR_C = 2'd2;
  localparam logic [1:0] FLOOR_D = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DWELL = 2'd2
  } panel_state_e;

  function automatic logic [NFLOORS-1:0] floor_onehot(input logic [1:0] f);
    logic [NFLOORS-1:0] one;
    one = {{(NFLOORS-1){1'b0}}, 1'b1};
    return one << f;
  endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Button/lamp side and controller side signals of the call panel; the panel is the slave.
interface elevator_call_panel_if;
  import elevator_pkg::*;

  logic [NFLOORS-1:0] btn;
  logic [1:0]         floor;
  logic               dir;
  logic               ra;
  logic               rb;
  logic               rc;
  logic               rd;
  logic [NFLOORS-1:0] lamp;
  logic               door_open;
  logic               busy;

  modport master (
    output btn, floor, dir,
    input  ra, rb, rc, rd, lamp, door_open, busy
  );

  modport slave (
    input  btn, floor, dir,
    output ra, rb, rc, rd, lamp, door_open, busy
  );

endinterface

// File: rtl/elevator_call_panel_dwell_timer.sv
// Door-dwell down-counter: load sets DWELL_CYCLES-1, counts down while enabled, stops at zero.
module dwell_timer #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(DWELL_CYCLES + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = W'(DWELL_CYCLES - 1);
    end else if (en && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == {W{1'b0}});

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: latches button presses, drives controller requests, times door dwell.
// Optional ELEV_CALL_CANCEL_EN: pressing an already-pending floor cancels that call.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_call_panel_if.slave bus
);

  panel_state_e       state_q, state_d;
  logic [NFLOORS-1:0] btn_q;
  logic [NFLOORS-1:0] pend_q, pend_d;
  logic [NFLOORS-1:0] press_s, floor_oh_s, set_s, cancel_s, kept_s, base_s, retire_s, req_s;
  logic               dwell_s, load_s, done_s, unused_dir_s;

  assign press_s      = bus.btn & ~btn_q;
  assign floor_oh_s   = floor_onehot(bus.floor);
  assign dwell_s      = (state_q == DWELL);
  assign unused_dir_s = bus.dir;

`ifdef ELEV_CALL_CANCEL_EN
  // The floor being dwelt at is never cancelled; a press there only reopens the door
  assign cancel_s = press_s & pend_q & ~(dwell_s ? floor_oh_s : {NFLOORS{1'b0}});
  assign set_s    = press_s & ~pend_q;
`else
  assign cancel_s = {NFLOORS{1'b0}};
  assign set_s    = press_s;
`endif

  assign kept_s   = pend_q & ~cancel_s;
  assign base_s   = kept_s | set_s;
  assign retire_s = (base_s & ~floor_oh_s) | (press_s & floor_oh_s);

  // Next-state and pending-call update
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE, SERVE: begin
        pend_d = base_s;
        if (|(kept_s & floor_oh_s)) begin
          state_d = DWELL;
          load_s  = 1'b1;
        end else if (state_q == IDLE) begin
          state_d = (|pend_q) ? SERVE : IDLE;
        end else begin
          state_d = (|pend_q) ? SERVE : IDLE;
        end
      end
      DWELL: begin
        if (done_s) begin
          pend_d  = retire_s;
          state_d = (|retire_s) ? SERVE : IDLE;
        end else begin
          pend_d = base_s;
          load_s = |(press_s & floor_oh_s);
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = {NFLOORS{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q   <= {NFLOORS{1'b0}};
      pend_q  <= {NFLOORS{1'b0}};
    end else begin
      state_q <= state_d;
      btn_q   <= bus.btn;
      pend_q  <= pend_d;
    end
  end

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk (clk),
    .rst (rst),
    .load(load_s),
    .en  (dwell_s),
    .done(done_s)
  );

  // While dwelling only the current floor is requested so the controller holds position
  assign req_s         = dwell_s ? floor_oh_s : pend_q;
  assign bus.ra        = req_s[0];
  assign bus.rb        = req_s[1];
  assign bus.rc        = req_s[2];
  assign bus.rd        = req_s[3];
  assign bus.lamp      = pend_q;
  assign bus.door_open = dwell_s;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed self-checking bench for elevator_call_panel with DWELL_CYCLES=4.
// Cancel expectations follow ELEV_CALL_CANCEL_EN.
module tb_elevator_call_panel;
  import elevator_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  elevator_call_panel_if bus ();

  elevator_call_panel #(
    .DWELL_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [3:0] req;
  assign req = {bus.rd, bus.rc, bus.rb, bus.ra};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.btn   = 4'b0000;
    bus.floor = FLOOR_A;
    bus.dir   = DIR_UP;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if ({req, bus.lamp, bus.door_open, bus.busy} !== 10'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got req=%b lamp=%b door=%b busy=%b, want all 0",
                 i, req, bus.lamp, bus.door_open, bus.busy);
      end
    end
  endtask

  task automatic test_single_call();
    cyc();
    bus.btn = 4'b0100;
    cyc();
    bus.btn = 4'b0000;
    checks++;
    if (bus.rc !== 1'b1 || bus.lamp !== 4'b0100) begin
      errors++;
      $display("FAIL call_latch: got rc=%b lamp=%b, want rc=1 lamp=0100", bus.rc, bus.lamp);
    end
    cyc();
    bus.floor = FLOOR_B;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.rc !== 1'b1 || bus.door_open !== 1'b0) begin
      errors++;
      $display("FAIL serve_state: got busy=%b rc=%b door=%b, want 1 1 0", bus.busy, bus.rc, bus.door_open);
    end
    cyc();
    bus.floor = FLOOR_C;
    for (int i = 5; i <= 8; i++) begin
      cyc();
      checks++;
      if (bus.door_open !== 1'b1) begin
        errors++;
        $display("FAIL dwell_open cycle %0d: got door=%b, want 1", i, bus.door_open);
      end
    end
    cyc();
    checks++;
    if (bus.lamp !== 4'b0000 || bus.busy !== 1'b0 || bus.door_open !== 1'b0) begin
      errors++;
      $display("FAIL retire: got lamp=%b busy=%b door=%b, want 0000 0 0", bus.lamp, bus.busy, bus.door_open);
    end
  endtask

  task automatic test_dwell_hold();
    cyc();
    bus.floor = FLOOR_B;
    bus.btn   = 4'b1010;
    cyc();
    bus.btn = 4'b0000;
    checks++;
    if (bus.lamp !== 4'b1010 || bus.door_open !== 1'b0) begin
      errors++;
      $display("FAIL hold_latch: got lamp=%b door=%b, want 1010 0", bus.lamp, bus.door_open);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.door_open !== 1'b1 || req !== 4'b0010) begin
        errors++;
        $display("FAIL hold_req dwell %0d: got door=%b req=%b, want 1 0010", i, bus.door_open, req);
      end
    end
    cyc();
    checks++;
    if (bus.busy !== 1'b1 || bus.door_open !== 1'b0 || bus.rd !== 1'b1 || bus.lamp !== 4'b1000) begin
      errors++;
      $display("FAIL hold_after: got busy=%b door=%b rd=%b lamp=%b, want 1 0 1 1000",
               bus.busy, bus.door_open, bus.rd, bus.lamp);
    end
    bus.floor = FLOOR_D;
    for (int i = 0; i < 6; i++) cyc();
    checks++;
    if (bus.lamp !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_clear: got lamp=%b busy=%b, want 0000 0", bus.lamp, bus.busy);
    end
  endtask

  task automatic test_repress();
    int door_cnt;
    door_cnt = 0;
    cyc();
    bus.floor = FLOOR_A;
    bus.btn   = 4'b0001;
    cyc();
    bus.btn = 4'b0000;
    cyc();
    if (bus.door_open === 1'b1) door_cnt++;
    cyc();
    if (bus.door_open === 1'b1) door_cnt++;
    bus.btn = 4'b0001;
    cyc();
    bus.btn = 4'b0000;
    if (bus.door_open === 1'b1) door_cnt++;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (bus.door_open === 1'b1) door_cnt++;
    end
    checks++;
    if (door_cnt !== 6) begin
      errors++;
      $display("FAIL repress_len: got door cycles=%0d, want 6", door_cnt);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.lamp !== 4'b0000) begin
      errors++;
      $display("FAIL repress_end: got busy=%b lamp=%b, want 0 0000", bus.busy, bus.lamp);
    end
  endtask

  task automatic test_held_button();
    int door_cnt;
    door_cnt = 0;
    cyc();
    bus.floor = FLOOR_D;
    bus.btn   = 4'b1000;
    for (int i = 1; i < 10; i++) begin
      cyc();
      if (bus.door_open === 1'b1) door_cnt++;
      if (i == 1) begin
        checks++;
        if (bus.lamp !== 4'b1000) begin
          errors++;
          $display("FAIL held_latch: got lamp=%b, want 1000", bus.lamp);
        end
      end
    end
    checks++;
    if (bus.lamp !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_single: got lamp=%b busy=%b while held, want 0000 0", bus.lamp, bus.busy);
    end
    checks++;
    if (door_cnt !== 4) begin
      errors++;
      $display("FAIL held_dwell: got door cycles=%0d, want 4", door_cnt);
    end
    bus.btn = 4'b0000;
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (bus.lamp !== 4'b0000) begin
      errors++;
      $display("FAIL held_release: got lamp=%b, want 0000", bus.lamp);
    end
  endtask

  task automatic test_reset_mid_dwell();
    cyc();
    bus.floor = FLOOR_C;
    bus.btn   = 4'b0100;
    cyc();
    bus.btn = 4'b0000;
    cyc();
    cyc();
    checks++;
    if (bus.door_open !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got door=%b, want 1", bus.door_open);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({req, bus.lamp, bus.door_open, bus.busy} !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid_dwell: got req=%b lamp=%b door=%b busy=%b, want all 0",
               req, bus.lamp, bus.door_open, bus.busy);
    end
    cyc();
    checks++;
    if (bus.busy !== 1'b0 || bus.lamp !== 4'b0000) begin
      errors++;
      $display("FAIL rst_after: got busy=%b lamp=%b, want 0 0000", bus.busy, bus.lamp);
    end
  endtask

  task automatic test_cancel();
    logic exp_lamp3;
    logic exp_busy;
`ifdef ELEV_CALL_CANCEL_EN
    exp_lamp3 = 1'b0;
    exp_busy  = 1'b0;
`else
    exp_lamp3 = 1'b1;
    exp_busy  = 1'b1;
`endif
    cyc();
    bus.floor = FLOOR_A;
    bus.btn   = 4'b1000;
    cyc();
    bus.btn = 4'b0000;
    checks++;
    if (bus.lamp[3] !== 1'b1) begin
      errors++;
      $display("FAIL cancel_first: got lamp[3]=%b, want 1", bus.lamp[3]);
    end
    cyc();
    cyc();
    bus.btn = 4'b1000;
    cyc();
    bus.btn = 4'b0000;
    cyc();
    cyc();
    checks++;
    if (bus.lamp[3] !== exp_lamp3 || bus.busy !== exp_busy) begin
      errors++;
      $display("FAIL cancel_second: got lamp[3]=%b busy=%b, want %b %b",
               bus.lamp[3], bus.busy, exp_lamp3, exp_busy);
    end
    bus.floor = FLOOR_D;
    for (int i = 0; i < 8; i++) cyc();
    checks++;
    if (bus.busy !== 1'b0 || bus.lamp !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_drain: got busy=%b lamp=%b, want 0 0000", bus.busy, bus.lamp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_call();
    test_dwell_hold();
    test_repress();
    test_held_button();
    test_reset_mid_dwell();
    test_cancel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
